// File: rtl/usb_rx_sipo.sv
// USB receive serial-in/parallel-out: NRZI decode, SYNC detect, bit de-stuffing,
// LSB-first byte assembly into the port fifo, and per-packet status reporting.
module usb_rx_sipo #(
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             line_bit,
  input  logic             line_bit_val,
  input  logic             eop_det,
  input  logic             fifo_full,
  output logic [7:0]       w_data,
  output logic             wr_en,
  output logic             pkt_start,
  output logic             pkt_done,
  output logic [CNT_W-1:0] pkt_byte_count,
  output logic             err_sync,
  output logic             err_stuff,
  output logic             err_overflow,
  output logic             err_partial,
  output logic             busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SYNC  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam logic [2:0] MIN_Z   = 3'(SYNC_MIN_ZEROS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic             prev_q, prev_d;
  logic [2:0]       ones_q, ones_d, bit_q, bit_d, zero_q, zero_d;
  logic [7:0]       shift_q, shift_d, w_data_q, w_data_d;
  logic             wr_en_q, wr_en_d, start_q, start_d, done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_sync_q, e_sync_d, e_stuff_q, e_stuff_d;
  logic             e_ovf_q, e_ovf_d, e_part_q, e_part_d;
  logic             dec, bit_ok;
  logic [7:0]       nxt_shift;

  assign dec       = (line_bit == prev_q);
  // EOP wins over a coincident bit strobe; that bit is never decoded.
  assign bit_ok    = line_bit_val && !eop_det;
  assign nxt_shift = {dec, shift_q[7:1]};

  always_comb begin
    state_d   = state_q;
    prev_d    = bit_ok ? line_bit : prev_q;
    ones_d    = ones_q;
    bit_d     = bit_q;
    zero_d    = zero_q;
    shift_d   = shift_q;
    w_data_d  = w_data_q;
    wr_en_d   = 1'b0;
    start_d   = 1'b0;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    e_sync_d  = e_sync_q;
    e_stuff_d = e_stuff_q;
    e_ovf_d   = e_ovf_q;
    e_part_d  = e_part_q;
    case (state_q)
      S_IDLE: begin
        if (bit_ok && !dec) begin
          state_d = S_SYNC;
          zero_d  = 3'd1;
        end
      end
      S_SYNC: begin
        if (eop_det) begin
          e_sync_d = 1'b1;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else if (bit_ok) begin
          if (!dec) begin
            zero_d = (zero_q == 3'd7) ? 3'd7 : zero_q + 3'd1;
          end else if (zero_q >= MIN_Z) begin
            state_d   = S_DATA;
            start_d   = 1'b1;
            cnt_d     = '0;
            e_sync_d  = 1'b0;
            e_stuff_d = 1'b0;
            e_ovf_d   = 1'b0;
            e_part_d  = 1'b0;
            ones_d    = 3'd1;
            bit_d     = 3'd0;
          end else begin
            e_sync_d = 1'b1;
            state_d  = S_DRAIN;
          end
        end
      end
      S_DATA: begin
        if (eop_det) begin
          if (bit_q != 3'd0) e_part_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (bit_ok) begin
          if (ones_q == 3'd6) begin
            if (!dec) ones_d = 3'd0;
            else begin
              e_stuff_d = 1'b1;
              state_d   = S_DRAIN;
            end
          end else begin
            shift_d = nxt_shift;
            bit_d   = bit_q + 3'd1;
            ones_d  = dec ? ones_q + 3'd1 : 3'd0;
            if (bit_q == 3'd7) begin
              if (!fifo_full) begin
                wr_en_d  = 1'b1;
                w_data_d = nxt_shift;
                cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
              end else begin
                e_ovf_d = 1'b1;
                state_d = S_DRAIN;
              end
            end
          end
        end
      end
      default: begin
        if (eop_det) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
    // Leaving a packet always re-arms the decoder at idle J.
    if (state_q != S_IDLE && state_d == S_IDLE) begin
      prev_d = 1'b1;
      bit_d  = 3'd0;
      ones_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      prev_q    <= 1'b1;
      ones_q    <= '0;
      bit_q     <= '0;
      zero_q    <= '0;
      shift_q   <= '0;
      w_data_q  <= '0;
      wr_en_q   <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      e_sync_q  <= 1'b0;
      e_stuff_q <= 1'b0;
      e_ovf_q   <= 1'b0;
      e_part_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      ones_q    <= ones_d;
      bit_q     <= bit_d;
      zero_q    <= zero_d;
      shift_q   <= shift_d;
      w_data_q  <= w_data_d;
      wr_en_q   <= wr_en_d;
      start_q   <= start_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      e_sync_q  <= e_sync_d;
      e_stuff_q <= e_stuff_d;
      e_ovf_q   <= e_ovf_d;
      e_part_q  <= e_part_d;
    end
  end

  assign w_data         = w_data_q;
  assign wr_en          = wr_en_q;
  assign pkt_start      = start_q;
  assign pkt_done       = done_q;
  assign pkt_byte_count = cnt_q;
  assign err_sync       = e_sync_q;
  assign err_stuff      = e_stuff_q;
  assign err_overflow   = e_ovf_q;
  assign err_partial    = e_part_q;
  assign busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_usb_rx_sipo.sv
// Bench for usb_rx_sipo: NRZI/stuffing encoder drives a table of packets, plus
// hand-written stuff-error, short-SYNC and mid-packet reset sequences.
module tb_usb_rx_sipo;
  logic clk = 1'b0, rst = 1'b1;
  logic line_bit = 1'b1, line_bit_val = 1'b0, eop_det = 1'b0, fifo_full = 1'b0;
  logic [7:0] w_data, w_data3;
  logic wr_en, pkt_start, pkt_done, err_sync, err_stuff, err_overflow, err_partial, busy;
  logic wr_en3, pkt_start3, pkt_done3, err_sync3, err_stuff3, err_overflow3, err_partial3, busy3;
  logic [7:0] pkt_byte_count, pkt_byte_count3;

  always #5 clk = ~clk;

  usb_rx_sipo dut (
    .clk(clk), .rst(rst), .line_bit(line_bit), .line_bit_val(line_bit_val),
    .eop_det(eop_det), .fifo_full(fifo_full), .w_data(w_data), .wr_en(wr_en),
    .pkt_start(pkt_start), .pkt_done(pkt_done), .pkt_byte_count(pkt_byte_count),
    .err_sync(err_sync), .err_stuff(err_stuff), .err_overflow(err_overflow),
    .err_partial(err_partial), .busy(busy));

  usb_rx_sipo #(.SYNC_MIN_ZEROS(3)) dut3 (
    .clk(clk), .rst(rst), .line_bit(line_bit), .line_bit_val(line_bit_val),
    .eop_det(eop_det), .fifo_full(fifo_full), .w_data(w_data3), .wr_en(wr_en3),
    .pkt_start(pkt_start3), .pkt_done(pkt_done3), .pkt_byte_count(pkt_byte_count3),
    .err_sync(err_sync3), .err_stuff(err_stuff3), .err_overflow(err_overflow3),
    .err_partial(err_partial3), .busy(busy3));

  int n_cmp = 0, n_err = 0;
  logic lvl = 1'b1;
  int tb_ones = 0;
  logic [7:0] wq[$], wq3[$];
  int st_cnt = 0, dn_cnt = 0, st3_cnt = 0;

  always @(negedge clk) begin
    if (wr_en) wq.push_back(w_data);
    if (wr_en3) wq3.push_back(w_data3);
    if (pkt_start) st_cnt++;
    if (pkt_done) dn_cnt++;
    if (pkt_start3) st3_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wq.delete(); wq3.delete();
    st_cnt = 0; dn_cnt = 0; st3_cnt = 0;
  endtask

  // One decoded bit per cycle, NRZI encoded: 0 toggles the line, 1 holds it.
  task automatic send_dec(input logic d);
    lvl = d ? lvl : ~lvl;
    line_bit = lvl;
    line_bit_val = 1'b1;
    @(posedge clk); #1;
    line_bit_val = 1'b0;
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) send_dec(1'b0);
    send_dec(1'b1);
    tb_ones = 1;
  endtask

  task automatic send_data_bit(input logic d, input logic full);
    fifo_full = full;
    send_dec(d);
    fifo_full = 1'b0;
    tb_ones = d ? tb_ones + 1 : 0;
    if (tb_ones == 6) begin
      send_dec(1'b0);
      tb_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic full);
    for (int i = 0; i < 8; i++) send_data_bit(b[i], (i == 7) ? full : 1'b0);
  endtask

  task automatic send_eop();
    eop_det = 1'b1;
    @(posedge clk); #1;
    eop_det = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lvl = 1'b1;
    line_bit = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lvl = 1'b1;
    line_bit = 1'b1;
  endtask

  task automatic chk_status(input string tag, input logic [7:0] cnt, input logic [3:0] e);
    chk({tag, ".count"}, pkt_byte_count, cnt);
    chk({tag, ".errs"}, {err_sync, err_stuff, err_overflow, err_partial}, e);
    chk({tag, ".busy"}, busy, 0);
  endtask

  typedef struct {
    int             nb;
    logic [2:0][7:0] b;
    int             full_idx;
    int             extra;
    int             exp_wr;
    logic [7:0]     exp_cnt;
    logic [3:0]     exp_err;   // {sync, stuff, overflow, partial}
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{nb: 2, b: {8'h00, 8'h5A, 8'hC3}, full_idx: -1, extra: 0, exp_wr: 2, exp_cnt: 2, exp_err: 4'b0000};
    vecs[1] = '{nb: 1, b: {8'h00, 8'h00, 8'hFF}, full_idx: -1, extra: 0, exp_wr: 1, exp_cnt: 1, exp_err: 4'b0000};
    vecs[2] = '{nb: 1, b: {8'h00, 8'h00, 8'hA5}, full_idx: -1, extra: 3, exp_wr: 1, exp_cnt: 1, exp_err: 4'b0001};
    vecs[3] = '{nb: 3, b: {8'h33, 8'h22, 8'h11}, full_idx: 1,  extra: 0, exp_wr: 1, exp_cnt: 1, exp_err: 4'b0010};
    vecs[4] = '{nb: 3, b: {8'h7E, 8'hFF, 8'h00}, full_idx: -1, extra: 0, exp_wr: 3, exp_cnt: 3, exp_err: 4'b0000};

    do_reset();
    chk("reset.wr_en", wr_en, 0);
    chk("reset.w_data", w_data, 0);
    chk("reset.start_done", {pkt_start, pkt_done}, 0);
    chk_status("reset", 8'd0, 4'b0000);

    for (int v = 0; v < 5; v++) begin
      clear_mon();
      send_sync();
      for (int k = 0; k < vecs[v].nb; k++) send_byte(vecs[v].b[k], k == vecs[v].full_idx);
      for (int k = 0; k < vecs[v].extra; k++) send_data_bit(k[0] == 1'b0, 1'b0);
      send_eop();
      chk($sformatf("vec%0d.n_wr", v), wq.size(), vecs[v].exp_wr);
      for (int k = 0; k < vecs[v].exp_wr && k < wq.size(); k++)
        chk($sformatf("vec%0d.byte%0d", v, k), wq[k], vecs[v].b[k]);
      chk($sformatf("vec%0d.n_start", v), st_cnt, 1);
      chk($sformatf("vec%0d.n_done", v), dn_cnt, 1);
      chk_status($sformatf("vec%0d", v), vecs[v].exp_cnt, vecs[v].exp_err);
    end

    // Stuff violation: six ones then a 1 where the stuffed 0 belongs.
    clear_mon();
    send_sync();
    for (int i = 0; i < 5; i++) send_dec(1'b1);
    send_dec(1'b1);
    for (int i = 0; i < 10; i++) send_dec(i[0]);
    send_eop();
    chk("stuff_err.n_wr", wq.size(), 0);
    chk("stuff_err.n_done", dn_cnt, 1);
    chk_status("stuff_err", 8'd0, 4'b0100);

    // Short SYNC: three zeros then 1, seen by both SYNC_MIN_ZEROS settings.
    do_reset();
    clear_mon();
    for (int i = 0; i < 3; i++) send_dec(1'b0);
    send_dec(1'b1);
    tb_ones = 1;
    send_byte(8'h81, 1'b0);
    send_eop();
    chk("short_sync.n_start", st_cnt, 0);
    chk("short_sync.n_done", dn_cnt, 1);
    chk("short_sync.n_wr", wq.size(), 0);
    chk_status("short_sync", 8'd0, 4'b1000);
    chk("short_sync3.n_start", st3_cnt, 1);
    chk("short_sync3.n_wr", wq3.size(), 1);
    if (wq3.size() > 0) chk("short_sync3.byte", wq3[0], 8'h81);
    chk("short_sync3.errs", {err_sync3, err_stuff3, err_overflow3, err_partial3}, 0);
    chk("short_sync3.count", pkt_byte_count3, 1);

    // EOP during SYNC.
    clear_mon();
    send_dec(1'b0); send_dec(1'b0);
    send_eop();
    chk("eop_sync.n_done", dn_cnt, 1);
    chk("eop_sync.err_sync", err_sync, 1);

    // Reset after four data bits, then a clean packet.
    clear_mon();
    send_sync();
    for (int i = 0; i < 4; i++) send_dec(1'b1);
    chk("mid.busy_before", busy, 1);
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("mid.n_done", dn_cnt, 0);
    chk("mid.outs", {wr_en, pkt_start, pkt_done, err_sync, err_stuff, err_overflow, err_partial}, 0);
    chk("mid.w_data", w_data, 0);
    chk_status("mid", 8'd0, 4'b0000);
    clear_mon();
    send_sync();
    send_byte(8'h3C, 1'b0);
    send_eop();
    chk("after.n_wr", wq.size(), 1);
    if (wq.size() > 0) chk("after.byte", wq[0], 8'h3C);
    chk("after.n_done", dn_cnt, 1);
    chk_status("after", 8'd1, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected finish before 200000");
    $fatal(1);
  end
endmodule
